// File: rtl/ext_pkg.sv
// Shared definitions for the ext_pipe extender: opcode width and encodings.
package ext_pkg;

  localparam int unsigned EOP_W = 3;

  localparam logic [EOP_W-1:0] EXT_SEXT = 3'd0;
  localparam logic [EOP_W-1:0] EXT_ZEXT = 3'd1;
  localparam logic [EOP_W-1:0] EXT_LUI  = 3'd2;
  localparam logic [EOP_W-1:0] EXT_BOFF = 3'd3;
  localparam logic [EOP_W-1:0] EXT_LB   = 3'd4;
  localparam logic [EOP_W-1:0] EXT_LBU  = 3'd5;
  localparam logic [EOP_W-1:0] EXT_LH   = 3'd6;
  localparam logic [EOP_W-1:0] EXT_LHU  = 3'd7;

endpackage

// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe.
//   Request : in_valid/in_ready, eop, imm, din, lane, flush
//   Response: out_valid/out_ready, out_data, out_err
//   master = producer/consumer side, slave = the extender itself.
interface ext_pipe_if
  import ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [EOP_W-1:0] eop;
  logic [IN_W-1:0]  imm;
  logic [OUT_W-1:0] din;
  logic [1:0]       lane;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport master (
    output flush, in_valid, eop, imm, din, lane, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  flush, in_valid, eop, imm, din, lane, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/ext_core.sv
// Combinational extension datapath between pipeline stage 1 and stage 2.
//   eop/imm      : opcode and immediate operand
//   din/lane     : load word and byte address (only with EXT_PIPE_LOAD_MODES_EN)
//   result/err   : extended value and illegal/misaligned flag
// Build option: EXT_PIPE_LOAD_MODES_EN enables the lb/lbu/lh/lhu opcodes;
// without it those opcodes return 0 with err set.
module ext_core
  import ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 2
) (
  input  logic [EOP_W-1:0] eop,
  input  logic [IN_W-1:0]  imm,
`ifdef EXT_PIPE_LOAD_MODES_EN
  input  logic [OUT_W-1:0] din,
  input  logic [1:0]       lane,
`endif
  output logic [OUT_W-1:0] result,
  output logic             err
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_c;
  logic [OUT_W-1:0] zext_c;

  assign sext_c = {{PAD_W{imm[IN_W-1]}}, imm};
  assign zext_c = {{PAD_W{1'b0}}, imm};

`ifdef EXT_PIPE_LOAD_MODES_EN
  // Lane selection always works on the low 32 bits of the load word.
  logic [31:0] word_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign word_c = din[31:0];
  assign byte_c = word_c[{lane, 3'b000} +: 8];
  assign half_c = word_c[{lane[1], 4'b0000} +: 16];
`endif

  // Opcode decode; unknown/disabled opcodes fall through to the error result.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (eop)
      EXT_SEXT: result = sext_c;
      EXT_ZEXT: result = zext_c;
      EXT_LUI:  result = {imm, {PAD_W{1'b0}}};
      EXT_BOFF: result = sext_c << SHIFT;
`ifdef EXT_PIPE_LOAD_MODES_EN
      EXT_LB:   result = {{(OUT_W-8){byte_c[7]}}, byte_c};
      EXT_LBU:  result = {{(OUT_W-8){1'b0}}, byte_c};
      EXT_LH: begin
        if (lane[0]) err = 1'b1;
        else         result = {{(OUT_W-16){half_c[15]}}, half_c};
      end
      EXT_LHU: begin
        if (lane[0]) err = 1'b1;
        else         result = {{(OUT_W-16){1'b0}}, half_c};
      end
`endif
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Two-stage immediate / load-data extender with valid/ready backpressure.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : ext_pipe_if.slave (request, response and flush)
// Stage 1 captures the request, stage 2 holds the extended result.
// Build option: EXT_PIPE_LOAD_MODES_EN enables load opcodes and the
// stage-1 din/lane registers.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  ext_pipe_if.slave   bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [EOP_W-1:0] s1_eop_q,   s1_eop_d;
  logic [IN_W-1:0]  s1_imm_q,   s1_imm_d;
`ifdef EXT_PIPE_LOAD_MODES_EN
  logic [OUT_W-1:0] s1_din_q,   s1_din_d;
  logic [1:0]       s1_lane_q,  s1_lane_d;
`else
  logic             unused_load;
  assign unused_load = ^{bus.din, bus.lane};
`endif
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_data_q,  s2_data_d;
  logic             s2_err_q,   s2_err_d;

  logic             s2_adv_c;
  logic             in_ready_c;
  logic             accept_c;
  logic [OUT_W-1:0] core_data_c;
  logic             core_err_c;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .eop    (s1_eop_q),
    .imm    (s1_imm_q),
`ifdef EXT_PIPE_LOAD_MODES_EN
    .din    (s1_din_q),
    .lane   (s1_lane_q),
`endif
    .result (core_data_c),
    .err    (core_err_c)
  );

  // Ready chain and next-state for both stages; flush kills both valids.
  always_comb begin
    s2_adv_c   = !s2_valid_q | bus.out_ready;
    in_ready_c = !s1_valid_q | s2_adv_c;
    accept_c   = bus.in_valid & in_ready_c;

    s1_valid_d = s1_valid_q;
    s1_eop_d   = s1_eop_q;
    s1_imm_d   = s1_imm_q;
`ifdef EXT_PIPE_LOAD_MODES_EN
    s1_din_d   = s1_din_q;
    s1_lane_d  = s1_lane_q;
`endif
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;

    if (bus.flush) begin
      // Data registers keep their contents; only the valids are dropped.
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv_c) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_data_d = core_data_c;
          s2_err_d  = core_err_c;
        end
      end
      if (accept_c) begin
        s1_valid_d = 1'b1;
        s1_eop_d   = bus.eop;
        s1_imm_d   = bus.imm;
`ifdef EXT_PIPE_LOAD_MODES_EN
        s1_din_d   = bus.din;
        s1_lane_d  = bus.lane;
`endif
      end else if (s2_adv_c) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_eop_q   <= '0;
      s1_imm_q   <= '0;
`ifdef EXT_PIPE_LOAD_MODES_EN
      s1_din_q   <= '0;
      s1_lane_q  <= '0;
`endif
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_eop_q   <= s1_eop_d;
      s1_imm_q   <= s1_imm_d;
`ifdef EXT_PIPE_LOAD_MODES_EN
      s1_din_q   <= s1_din_d;
      s1_lane_q  <= s1_lane_d;
`endif
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_err   = s2_err_q;

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate/load-data extender for the datapath. Takes an IN_W-bit immediate or an OUT_W-bit load word plus an extension opcode, and produces an OUT_W-bit result two cycles later. The block uses a valid/ready handshake with full backpressure and a flush input. It sits between decode/MEM and the register-write path, and covers both immediate extension and lb/lbu/lh/lhu data extension.

## Interface
- IN_W, 16, immediate width; must satisfy IN_W < OUT_W
- OUT_W, 32, result width; must be ≥ 32 when load modes are compiled in
- SHIFT, 2, left shift for branch-offset mode; must satisfy IN_W+SHIFT ≤ OUT_W
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous; kills all in-flight entries
- in_valid  input  1  request valid
- in_ready  output  1  block can accept this cycle
- eop  input  3  extension opcode
- imm  input  IN_W  immediate operand
- din  input  OUT_W  load word (load modes only)
- lane  input  2  byte address low bits (load modes only)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_W  extended result
- out_err  output  1  illegal/misaligned flag travelling with out_data

## Operation
- eop encoding:
  - 0 SEXT: sign-extend imm.
  - 1 ZEXT: zero-extend imm.
  - 2 LUI: imm placed in the top IN_W bits, low bits 0.
  - 3 BOFF: sign-extend imm, then shift left by SHIFT; truncated to OUT_W.
  - 4 LB: sign-extend din byte[lane].
  - 5 LBU: zero-extend din byte[lane].
  - 6 LH: sign-extend din half[lane[1]].
  - 7 LHU: zero-extend din half[lane[1]].
- Byte index: byte[k] = din[8k+7:8k], taken within din[31:0].
- Misalignment: LH/LHU with lane[0]=1 → out_data=0, out_err=1. Every other legal op gives out_err=0.
- Stage 1 (S1) registers eop/imm/din/lane on an accepted request (in_valid & in_ready).
- Stage 2 (S2) registers the computed result and error flag from S1.
- Ready chain:
  - s2_adv = !s2_valid | out_ready
  - in_ready = !s1_valid | s2_adv
- S1 advances into S2 when s1_valid & s2_adv. S1 holds while S2 is stalled.
- Output stability: while out_valid & !out_ready, out_data and out_err are held stable.
- Priority per edge: reset > flush > normal operation.
- flush: clears s1_valid and s2_valid at the next edge. A request offered in the same cycle is discarded. out_data is not cleared.

## Timing
- Reset: out_valid=0, out_data=0, out_err=0, all internal valids 0. in_ready=1 in the first cycle after reset.
- Latency: a request accepted at edge N appears on out_valid/out_data after edge N+1 (2 registers), with out_ready held at 1.
- Throughput: one result per cycle with no bubbles while out_ready=1.
- Full condition: both stages valid and out_ready=0 → in_ready=0 in that same cycle (combinational path from out_ready).
- Simultaneous events:
  - Accept and output handshake in the same cycle: both complete, and the pipeline shifts.
  - Reset or flush mid-stall: drops all entries, no partial outputs.
- Reset during a transfer: the transfer is discarded. The first post-reset out_valid appears only for a request accepted after reset.

## Configuration
- EXT_PIPE_LOAD_MODES_EN:
  - Defined: eop 4–7 behave as above; OUT_W ≥ 32 is required.
  - Undefined: eop 4–7 are illegal and yield out_data=0, out_err=1. din and lane are ignored, and the S1 din/lane registers are removed.

## Structure
- Shared package ext_pkg holds:
  - eop localparams: EXT_SEXT, EXT_ZEXT, EXT_LUI, EXT_BOFF, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU
  - EOP_W = 3
- Sub-module ext_core: purely combinational S1→S2 compute (eop, imm, din, lane → result, err), parametrised by IN_W/OUT_W/SHIFT. ext_pipe holds the registers and the handshake logic.

## Test plan
- Immediate modes: imm=16'h8004, out_ready=1, eop=0/1/2/3 back-to-back → 32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010 on consecutive cycles, starting 2 cycles after the first accept.
- Load modes (EXT_PIPE_LOAD_MODES_EN defined), din=32'h80FF7F01:
  - LB lane=3 → 32'hFFFFFF80
  - LBU lane=2 → 32'h000000FF
  - LH lane=0 → 32'h00007F01
  - LHU lane=2 → 32'h000080FF
  - LH lane=1 → out_data=0, out_err=1
- Backpressure: 4 requests issued, out_ready=0 from cycle 2 → in_ready drops after 2 accepts and out_data is held. Release out_ready → all 4 results emerge in order with none lost or duplicated.
- Flush: flush asserted while both stages are valid and in_valid=1 → next cycle out_valid=0, and nothing from before the flush ever appears.
- Reset mid-stream: reset pulsed with a full, stalled pipeline → outputs go to 0 and in_ready=1 in the next cycle. The first request after reset returns exactly 2 cycles later.
- Macro off: eop=4, din=32'h000000FF → out_data=0, out_err=1.
